// File: rtl/mult_div_if.sv
// mult_div_if: EX-stage <-> multiply/divide sequencer bundle.
//   master (EX side)  drives op_valid, special2, funct, operand_1/2, hi_in, lo_in,
//                     ex_advance, flush; observes done, result, busy.
//   slave (sequencer) consumes the above and drives done, result {hi, lo}, busy.
interface mult_div_if;
  logic        op_valid;
  logic        special2;
  logic [5:0]  funct;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        ex_advance;
  logic        flush;
  logic        done;
  logic [63:0] result;
  logic        busy;

  modport master (
    output op_valid, special2, funct, operand_1, operand_2, hi_in, lo_in,
           ex_advance, flush,
    input  done, result, busy
  );

  modport slave (
    input  op_valid, special2, funct, operand_1, operand_2, hi_in, lo_in,
           ex_advance, flush,
    output done, result, busy
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: multi-cycle multiply/divide sequencer feeding the EX stage.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mult_div_if.slave -- op request from EX (op_valid/special2/funct,
//          operands, forwarded HI/LO, ex_advance, flush) and the response
//          (done, 64-bit {hi, lo} result, busy).
// Multiplies take 3 edges from accept (accept, MUL1, MUL2); divides use a
// DIV_ITER-step restoring divider plus a sign-fix cycle (34 edges). Divide by
// zero finishes on the accept edge. The result is held in DONE until EX
// advances; flush drops whatever is in flight.
module mult_div_ctrl #(
  parameter int DIV_ITER = 32
) (
  input logic        clk,
  input logic        rst,
  mult_div_if.slave  bus
);

  localparam int ITER_W = $clog2(DIV_ITER);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL1, S_MUL2, S_DIV, S_DIVFIX, S_DONE
  } state_t;

  typedef enum logic [1:0] {K_MUL, K_ADD, K_SUB} kind_t;

  state_t state_reg, state_next;

  // Latched operation context
  logic [31:0] op_a_reg, op_b_reg, hi_reg, lo_reg;
  logic        signed_reg;
  kind_t       kind_reg;
  logic [63:0] product_reg;

  // Divider state
  logic [31:0]       rem_reg, quot_reg, divisor_reg;
  logic              q_neg_reg, r_neg_reg;
  logic [ITER_W-1:0] iter_reg;

  logic [63:0] result_reg;
  logic        done_reg;

  // ---------------- op decode ----------------
  logic  is_mul_op, is_div_op, op_signed;
  kind_t op_kind;

  always_comb begin
    is_mul_op = 1'b0;
    is_div_op = 1'b0;
    op_signed = 1'b0;
    op_kind   = K_MUL;
    if (!bus.special2) begin
      case (bus.funct)
        6'b011000: begin is_mul_op = 1'b1; op_signed = 1'b1; end  // MULT
        6'b011001: is_mul_op = 1'b1;                              // MULTU
        6'b011010: begin is_div_op = 1'b1; op_signed = 1'b1; end  // DIV
        6'b011011: is_div_op = 1'b1;                              // DIVU
        default: ;
      endcase
    end else begin
      case (bus.funct)
        6'b000000: begin is_mul_op = 1'b1; op_signed = 1'b1; op_kind = K_ADD; end // MADD
        6'b000001: begin is_mul_op = 1'b1; op_kind = K_ADD; end                   // MADDU
        6'b000010: begin is_mul_op = 1'b1; op_signed = 1'b1; end                  // MUL
        6'b000100: begin is_mul_op = 1'b1; op_signed = 1'b1; op_kind = K_SUB; end // MSUB
        6'b000101: begin is_mul_op = 1'b1; op_kind = K_SUB; end                   // MSUBU
        default: ;
      endcase
    end
  end

  logic accept;
  assign accept = (state_reg == S_IDLE) && bus.op_valid && (is_mul_op || is_div_op)
                  && !bus.flush;

  logic divisor_zero;
  assign divisor_zero = (bus.operand_2 == 32'd0);

  // Magnitudes for the divider; -0x80000000 wraps to 0x80000000, which is
  // the correct unsigned magnitude.
  logic [31:0] dividend_abs, divisor_abs;
  assign dividend_abs = (op_signed && bus.operand_1[31]) ? -bus.operand_1 : bus.operand_1;
  assign divisor_abs  = (op_signed && bus.operand_2[31]) ? -bus.operand_2 : bus.operand_2;

  // ---------------- multiply datapath ----------------
  // Operands widened to 64 bits (sign- or zero-extended); the low 64 bits of
  // the product are the exact signed/unsigned 64-bit product.
  logic [63:0] a_wide, b_wide, product_full, acc, mul_result;
  assign a_wide       = {{32{signed_reg & op_a_reg[31]}}, op_a_reg};
  assign b_wide       = {{32{signed_reg & op_b_reg[31]}}, op_b_reg};
  assign product_full = a_wide * b_wide;
  assign acc          = {hi_reg, lo_reg};

  always_comb begin
    case (kind_reg)
      K_ADD:   mul_result = acc + product_reg;
      K_SUB:   mul_result = acc - product_reg;
      default: mul_result = product_reg;
    endcase
  end

  // ---------------- restoring divide step ----------------
  // rem_reg < divisor_reg always holds, so the shifted remainder is below
  // 2*divisor and bit 32 of the trial difference is a clean borrow flag.
  logic [32:0] shifted, trial;
  logic        fits;
  logic [31:0] rem_step, quot_step;
  assign shifted   = {rem_reg, quot_reg[31]};
  assign trial     = shifted - {1'b0, divisor_reg};
  assign fits      = !trial[32];
  assign rem_step  = fits ? trial[31:0] : shifted[31:0];
  assign quot_step = {quot_reg[30:0], fits};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (is_div_op) state_next = divisor_zero ? S_DONE : S_DIV;
          else           state_next = S_MUL1;
        end
      end
      S_MUL1:   state_next = S_MUL2;
      S_MUL2:   state_next = S_DONE;
      S_DIV:    if (iter_reg == ITER_W'(DIV_ITER - 1)) state_next = S_DIVFIX;
      S_DIVFIX: state_next = S_DONE;
      S_DONE:   if (bus.ex_advance) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (bus.flush) state_next = S_IDLE;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.busy   = (state_reg != S_IDLE);
    bus.done   = done_reg;
    bus.result = result_reg;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      signed_reg  <= 1'b0;
      kind_reg    <= K_MUL;
      product_reg <= '0;
      rem_reg     <= '0;
      quot_reg    <= '0;
      divisor_reg <= '0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      iter_reg    <= '0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
    end else if (bus.flush) begin
      done_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_a_reg   <= bus.operand_1;
            op_b_reg   <= bus.operand_2;
            hi_reg     <= bus.hi_in;
            lo_reg     <= bus.lo_in;
            signed_reg <= op_signed;
            kind_reg   <= op_kind;
            if (is_div_op) begin
              if (divisor_zero) begin
                result_reg <= {bus.operand_1, 32'hFFFF_FFFF};
                done_reg   <= 1'b1;
              end else begin
                rem_reg     <= '0;
                quot_reg    <= dividend_abs;
                divisor_reg <= divisor_abs;
                q_neg_reg   <= op_signed && (bus.operand_1[31] ^ bus.operand_2[31]);
                r_neg_reg   <= op_signed && bus.operand_1[31];
                iter_reg    <= '0;
              end
            end
          end
        end
        S_MUL1: product_reg <= product_full;
        S_MUL2: begin
          result_reg <= mul_result;
          done_reg   <= 1'b1;
        end
        S_DIV: begin
          rem_reg  <= rem_step;
          quot_reg <= quot_step;
          iter_reg <= iter_reg + 1'b1;
        end
        S_DIVFIX: begin
          result_reg <= {r_neg_reg ? -rem_reg : rem_reg,
                         q_neg_reg ? -quot_reg : quot_reg};
          done_reg   <= 1'b1;
        end
        S_DONE: if (bus.ex_advance) done_reg <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: each issued op pushes its expected
// result and completion cycle; a monitor pops and compares on every rising
// edge of done.
module tb_mult_div_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mult_div_if bus ();

  mult_div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compares on each new completion
  always @(negedge clk) begin
    if (bus.done === 1'b1 && done_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("op %s result %h at cycle %0d (due %0d)", e.name, bus.result, cyc, e.due);
        check({e.name, "_result"}, bus.result, e.res);
        check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
      end
    end
    done_prev = bus.done;
  end

  // Drives one op at a negedge; accept happens on the following posedge.
  task automatic issue(input logic sp2, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [63:0] exp, input int lat, input bit push,
                       input string name);
    exp_t e;
    @(negedge clk);
    bus.op_valid  = 1'b1;
    bus.special2  = sp2;
    bus.funct     = f;
    bus.operand_1 = a;
    bus.operand_2 = b;
    bus.hi_in     = hi;
    bus.lo_in     = lo;
    if (push) begin
      e.res = exp; e.due = cyc + lat; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.op_valid  = 1'b0;
    bus.operand_1 = 32'hDEAD_BEEF;   // later input changes must be ignored
    bus.operand_2 = 32'h0BAD_F00D;
    bus.hi_in     = 32'h5555_5555;
    bus.lo_in     = 32'hAAAA_AAAA;
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) got = 1;
    end
    if (!got) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Pulses ex_advance for one cycle and checks that done drops.
  task automatic retire_op(input string name);
    bus.ex_advance = 1'b1;
    @(negedge clk);
    bus.ex_advance = 1'b0;
    check({name, "_retire"}, 64'(bus.done), 64'd0);
  endtask

  task automatic run_op(input logic sp2, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input logic [63:0] exp, input int lat, input string name);
    issue(sp2, f, a, b, hi, lo, exp, lat, 1'b1, name);
    wait_done(name);
    retire_op(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.op_valid = 1'b0; bus.special2 = 1'b0; bus.funct = 6'd0;
    bus.operand_1 = '0; bus.operand_2 = '0; bus.hi_in = '0; bus.lo_in = '0;
    bus.ex_advance = 1'b0; bus.flush = 1'b0;

    #1 rst = 1'b1;
    #2;
    check("reset_done",   64'(bus.done), 64'd0);
    check("reset_busy",   64'(bus.busy), 64'd0);
    check("reset_result", bus.result,    64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Multiplies
    run_op(1'b0, 6'b011000, 32'hFFFF_FFFE, 32'd3, 0, 0, 64'hFFFF_FFFF_FFFF_FFFA, 3, "MULT");
    run_op(1'b0, 6'b011001, 32'hFFFF_FFFE, 32'd3, 0, 0, 64'h0000_0002_FFFF_FFFA, 3, "MULTU");
    run_op(1'b1, 6'b000010, 32'd5, 32'hFFFF_FFFD, 0, 0, 64'hFFFF_FFFF_FFFF_FFF1, 3, "MUL");
    run_op(1'b1, 6'b000100, 32'd1, 32'd1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 3, "MSUB");
    run_op(1'b1, 6'b000101, 32'hFFFF_FFFF, 32'd2, 0, 32'd10, 64'hFFFF_FFFE_0000_000C, 3, "MSUBU");
    run_op(1'b1, 6'b000000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 64'h0000_0000_0000_0001, 3, "MADD_neg");
    run_op(1'b1, 6'b000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 64'hFFFF_FFFE_0000_0001, 3, "MADDU");

    // Divides
    run_op(1'b0, 6'b011010, 32'hFFFF_FFF9, 32'd2, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 34, "DIV");
    run_op(1'b0, 6'b011011, 32'd7, 32'd2, 0, 0, 64'h0000_0001_0000_0003, 34, "DIVU");
    run_op(1'b0, 6'b011010, 32'h0000_1234, 32'd0, 0, 0, 64'h0000_1234_FFFF_FFFF, 1, "DIV_by0");
    run_op(1'b0, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 64'h0000_0000_8000_0000, 34, "DIV_ovf");

    // Unrecognised op is ignored
    @(negedge clk);
    bus.op_valid = 1'b1; bus.special2 = 1'b1; bus.funct = 6'b000011;
    @(negedge clk);
    check("unrec_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("unrec_done", 64'(bus.done), 64'd0);
    bus.op_valid = 1'b0;

    // Hold in DONE for 5 cycles, then retire and follow with a MULTU
    issue(1'b1, 6'b000000, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF,
          64'h0000_0001_0000_0000, 3, 1'b1, "MADD");
    wait_done("MADD");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_done",   64'(bus.done), 64'd1);
      check("hold_result", bus.result, 64'h0000_0001_0000_0000);
    end
    retire_op("MADD");
    run_op(1'b0, 6'b011001, 32'h0001_0000, 32'h0001_0000, 0, 0, 64'h0000_0001_0000_0000, 3, "MULTU_after_hold");

    // Flush at divide iteration 10: no completion, then a fresh op works
    issue(1'b0, 6'b011011, 32'd100, 32'd7, 0, 0, 64'd0, 34, 1'b0, "DIVU_flushed");
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_done", 64'(bus.done), 64'd0);
    repeat (40) @(negedge clk);
    run_op(1'b0, 6'b011011, 32'd100, 32'd7, 0, 0, 64'h0000_0002_0000_000E, 34, "DIVU_after_flush");

    // Async reset in MUL1
    issue(1'b0, 6'b011000, 32'd9, 32'd9, 0, 0, 64'd0, 3, 1'b0, "MULT_reset");
    check("mul1_busy", 64'(bus.busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_done",   64'(bus.done), 64'd0);
    check("async_rst_busy",   64'(bus.busy), 64'd0);
    check("async_rst_result", bus.result,    64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_op(1'b0, 6'b011001, 32'd6, 32'd7, 0, 0, 64'h0000_0000_0000_002A, 3, "MULTU_after_rst");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Multi-cycle multiply/divide sequencer that drives the EX stage's `mult_div_done_flag` and `mult_div_result` inputs. It accepts one operation when EX holds a valid MULT/MULTU/DIV/DIVU/MUL/MADD/MADDU/MSUB/MSUBU. It computes the 64-bit result: a 2-cycle multiply path, or a 32-iteration restoring divider. It then holds the result until the pipeline advances EX or flushes it.

Parameters:
DIV_ITER, 32, number of divider iterations (one quotient bit per cycle; fixed at operand width)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
op_valid  input  1  EX holds a live instruction (not a bubble)
special2  input  1  1 = funct is a SPECIAL2 code (MUL/MADD/MADDU/MSUB/MSUBU); 0 = SPECIAL code
funct  input  6  instruction funct field
operand_1  input  32  rs value / dividend
operand_2  input  32  rt value / divisor
hi_in  input  32  current HI (forwarded), used by MADD/MSUB
lo_in  input  32  current LO (forwarded), used by MADD/MSUB
ex_advance  input  1  EX instruction leaves EX this cycle
flush  input  1  pipeline flush (exception/eret)
done  output  1  result valid; registered
result  output  64  {hi, lo}; for MUL, low word is the GPR result
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; done=0; result=0; busy=0; all internal registers cleared. Reset mid-operation aborts with no residue.
- Recognised ops:
  - special2=0: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - special2=1: MADD 000000, MADDU 000001, MUL 000010, MSUB 000100, MSUBU 000101.
  - Anything else is ignored; IDLE is held and done=0.
- FSM states: IDLE, MUL1, MUL2, DIV, DIVFIX, DONE.
- IDLE:
  - On op_valid and a recognised op, latch operand_1, operand_2, hi_in, lo_in, signedness and op kind.
  - Multiply ops -> MUL1. Divide ops -> DIV.
  - DIV/DIVU with operand_2==0 -> DONE directly, with result={operand_1, 32'hFFFFFFFF}.
- MUL1: register 64-bit product. Signed ops use a 33-bit sign-extended multiply; U ops zero-extend.
- MUL2:
  - MULT/MULTU/MUL: result=product.
  - MADD(U): result={hi,lo}+product. MSUB(U): result={hi,lo}-product. Both are mod 2^64.
  - Go to DONE.
  - Multiply latency: done rises 3 clock edges after the IDLE-accept edge window, i.e. accept edge, MUL1 edge, MUL2 edge.
- DIV:
  - At accept, store |dividend|, |divisor| and sign flags (quotient negative iff signs differ; remainder takes the dividend sign).
  - Each cycle does one restoring step: shift {rem,quot} left 1, trial subtract the divisor, set the quotient bit.
  - An iteration counter of 0..31 moves to DIVFIX after the 32nd step.
- DIVFIX: apply the sign corrections; result={remainder, quotient}; go to DONE. Divide latency is 34 edges from accept.
- Signed DIV edge cases:
  - 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. No trap.
  - Unsigned ops never negate.
- DONE:
  - done=1 and result are stable.
  - On ex_advance, go to IDLE with done=0. The next op is accepted no earlier than the following cycle, so back-to-back ops see one bubble cycle.
- flush in any state (synchronous): go to IDLE, done=0, and drop the operation. flush dominates ex_advance and accept.
- Latched operands are frozen after accept. Input changes during MUL*/DIV/DIVFIX/DONE are ignored.
- EX uses stall_request = recognised op && !done for all nine ops.
- result keeps its last value in IDLE. Only done qualifies it.

Test Plan:
- MULT with op1=0xFFFFFFFE (-2), op2=3 -> after 3 edges done=1, result=0xFFFFFFFF_FFFFFFFA. MULTU with the same operands -> 0x00000002_FFFFFFFA.
- MADD with hi=0, lo=0xFFFFFFFF, op1=1, op2=1 -> result=0x00000001_00000000. MSUB with hi=lo=0, op1=1, op2=1 -> 0xFFFFFFFF_FFFFFFFF.
- DIV with op1=-7 (0xFFFFFFF9), op2=2 -> done exactly 34 edges after accept, result={0xFFFFFFFF, 0xFFFFFFFD}. DIVU with op1=7, op2=2 -> {1, 3}.
- DIV with op2=0, op1=0x1234 -> done the cycle after accept, result={0x00001234, 0xFFFFFFFF}. DIV 0x80000000 / -1 -> {0, 0x80000000}.
- Hold ex_advance=0 for 5 cycles in DONE -> done and result stay stable. Pulse ex_advance -> done=0 next cycle. A new MULTU is then accepted and completes normally.
- Assert flush at DIV iteration 10 -> IDLE next cycle, done never rises, and a new op is accepted afterwards. Assert rst mid-MUL1 -> all outputs 0 immediately, without waiting for clk.
